fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and ROM bank-select encodings for the fetch sequencer and its queue.
package fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam logic [1:0] SEL0_BANK0 = 2'd0;
    localparam logic [1:0] SEL0_BANK1 = 2'd2;
    localparam logic       SEL1_BANK0 = 1'b0;
    localparam logic       SEL1_BANK1 = 1'b1;

    localparam int HW_ADDR_W = 15;
    typedef logic [HW_ADDR_W-1:0] hw_addr_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue of {halfword, PC}: push two, pop zero to two, flush,
// with head and head+1 read ports that read as zero when empty.
module fetch_queue #(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 15,
    parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [1:0]       pop_i,
    input  logic [15:0]      wdata0_i,
    input  logic [15:0]      wdata1_i,
    input  logic [PC_W-1:0]  wpc0_i,
    input  logic [PC_W-1:0]  wpc1_i,
    output logic [15:0]      head0_o,
    output logic [15:0]      head1_o,
    output logic [PC_W-1:0]  head0_pc_o,
    output logic             head0_valid_o,
    output logic             head1_valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [15:0]      inst_mem [QDEPTH];
    logic [PC_W-1:0]  pc_mem   [QDEPTH];

    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0] wr_nxt, rd_nxt;
    logic [CNT_W-1:0] count_q, count_d;

    assign wr_nxt = wr_q + PTR_W'(1);
    assign rd_nxt = rd_q + PTR_W'(1);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            rd_d    = rd_q + PTR_W'(pop_i);
            wr_d    = push_i ? (wr_q + PTR_W'(2)) : wr_q;
            count_d = count_q - CNT_W'(pop_i) + (push_i ? CNT_W'(2) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage is never reset; validity comes only from count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            inst_mem[wr_q]   <= wdata0_i;
            pc_mem[wr_q]     <= wpc0_i;
            inst_mem[wr_nxt] <= wdata1_i;
            pc_mem[wr_nxt]   <= wpc1_i;
        end
    end

    assign head0_valid_o = (count_q != '0);
    assign head1_valid_o = (count_q >= CNT_W'(2));
    assign head0_o       = head0_valid_o ? inst_mem[rd_q]   : 16'h0000;
    assign head0_pc_o    = head0_valid_o ? pc_mem[rd_q]     : '0;
    assign head1_o       = head1_valid_o ? inst_mem[rd_nxt] : 16'h0000;
    assign count_o       = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller for the dual-bank halfword ROM: owns the fetch PC, BOOT/RUN FSM,
// bank-select decode and feeds two halfwords per cycle into the instruction queue.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ROW_W    = 14,
    parameter int RESET_PC = 0,
    parameter int QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROW_W-1:0] rom_addr,
    output logic             pc_1,
    output logic             sel_mem_1,
    output logic [1:0]       sel_mem_0,
    input  logic [15:0]      rom_ir_0,
    input  logic [15:0]      rom_ir_1,
    input  logic [1:0]       consume,
    input  logic             branch_valid,
    input  logic [ROW_W:0]   branch_target,
    output logic [15:0]      inst0,
    output logic [15:0]      inst1,
    output logic             inst0_valid,
    output logic             inst1_valid,
    output logic [ROW_W:0]   inst0_pc
);

    localparam int PC_W  = ROW_W + 1;
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] fetch_pc_inc;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] consume_w;
    logic [1:0]      pop;
    logic            run, flush, push;

    assign run          = (state_q == RUN);
    assign flush        = run && branch_valid;
    assign consume_w    = CNT_W'(consume);
    assign fetch_pc_inc = fetch_pc_q + PC_W'(1);

    // An over-large pop is clamped to what the queue holds.
    always_comb begin
        pop = consume;
        if (flush)
            pop = 2'd0;
        else if (consume_w > q_count)
            pop = q_count[1:0];
    end

    assign push = run && !branch_valid && ((q_count - CNT_W'(pop)) <= CNT_W'(QDEPTH - 2));

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= BOOT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT)
            state_d = RUN;
    end

    always_comb begin
        rom_addr  = '0;
        pc_1      = 1'b0;
        sel_mem_0 = SEL0_BANK0;
        sel_mem_1 = SEL1_BANK0;
        if (run) begin
            rom_addr = fetch_pc_q[PC_W-1:1];
            if (fetch_pc_q[0]) begin
                pc_1      = 1'b1;
                sel_mem_0 = SEL0_BANK1;
                sel_mem_1 = SEL1_BANK0;
            end else begin
                sel_mem_0 = SEL0_BANK0;
                sel_mem_1 = SEL1_BANK1;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (!run)
            fetch_pc_d = PC_W'(RESET_PC);
        else if (branch_valid)
            fetch_pc_d = branch_target;
        else if (push)
            fetch_pc_d = fetch_pc_q + PC_W'(2);
    end

    always_ff @(posedge clk) begin
        if (rst)
            fetch_pc_q <= PC_W'(RESET_PC);
        else
            fetch_pc_q <= fetch_pc_d;
    end

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .push_i        (push),
        .pop_i         (pop),
        .wdata0_i      (rom_ir_0),
        .wdata1_i      (rom_ir_1),
        .wpc0_i        (fetch_pc_q),
        .wpc1_i        (fetch_pc_inc),
        .head0_o       (inst0),
        .head1_o       (inst1),
        .head0_pc_o    (inst0_pc),
        .head0_valid_o (inst0_valid),
        .head1_valid_o (inst1_valid),
        .count_o       (q_count)
    );

    a_consume_legal: assert property (@(posedge clk) disable iff (rst)
        flush || ((consume != 2'd3) && (consume_w <= q_count)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a ROM model on the bank lines plus a queue-of-PCs
// reference model driven by directed and random consume/branch/reset stimulus.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int ROW_W    = 14;
    localparam int RESET_PC = 0;
    localparam int QDEPTH   = 4;
    localparam int NHW      = 1 << (ROW_W + 1);

    logic             clk;
    logic             rst;
    logic [ROW_W-1:0] rom_addr;
    logic             pc_1;
    logic             sel_mem_1;
    logic [1:0]       sel_mem_0;
    logic [15:0]      rom_ir_0;
    logic [15:0]      rom_ir_1;
    logic [1:0]       consume;
    logic             branch_valid;
    logic [ROW_W:0]   branch_target;
    logic [15:0]      inst0;
    logic [15:0]      inst1;
    logic             inst0_valid;
    logic             inst1_valid;
    logic [ROW_W:0]   inst0_pc;

    fetch_sequencer #(
        .ROW_W    (ROW_W),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .pc_1          (pc_1),
        .sel_mem_1     (sel_mem_1),
        .sel_mem_0     (sel_mem_0),
        .rom_ir_0      (rom_ir_0),
        .rom_ir_1      (rom_ir_1),
        .consume       (consume),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .inst0         (inst0),
        .inst1         (inst1),
        .inst0_valid   (inst0_valid),
        .inst1_valid   (inst1_valid),
        .inst0_pc      (inst0_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Halfword image; bank 0 holds even halfwords, bank 1 odd ones.
    logic [15:0] mem [NHW];
    logic [ROW_W-1:0] row0_sel;

    always_comb begin
        row0_sel = rom_addr + ROW_W'(pc_1);
        rom_ir_0 = (sel_mem_0 == 2'd2) ? mem[{rom_addr, 1'b1}] : mem[{rom_addr, 1'b0}];
        rom_ir_1 = sel_mem_1 ? mem[{rom_addr, 1'b1}] : mem[{row0_sel, 1'b0}];
    end

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the queue is a list of halfword PCs; contents come from mem.
    int       q_pc[$];
    hw_addr_t m_pc;
    bit       m_boot;

    task automatic model_edge(input bit r, input int c, input bit b, input hw_addr_t t);
        hw_addr_t nx;
        if (r) begin
            q_pc.delete();
            m_boot = 1'b1;
            m_pc   = hw_addr_t'(RESET_PC);
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = hw_addr_t'(RESET_PC);
        end else if (b) begin
            q_pc.delete();
            m_pc = t;
        end else begin
            for (int i = 0; i < c; i++) void'(q_pc.pop_front());
            if (q_pc.size() <= QDEPTH - 2) begin
                nx = m_pc + hw_addr_t'(1);
                q_pc.push_back(int'(m_pc));
                q_pc.push_back(int'(nx));
                m_pc = m_pc + hw_addr_t'(2);
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = q_pc.size();
        expect_eq("v0", inst0_valid, n >= 1);
        expect_eq("v1", inst1_valid, n >= 2);
        expect_eq("inst0", inst0, (n >= 1) ? mem[q_pc[0]] : 16'h0);
        expect_eq("inst0_pc", inst0_pc, (n >= 1) ? q_pc[0] : 0);
        expect_eq("inst1", inst1, (n >= 2) ? mem[q_pc[1]] : 16'h0);
        if (m_boot) begin
            expect_eq("boot_rom_addr", rom_addr, 0);
            expect_eq("boot_pc_1", pc_1, 0);
            expect_eq("boot_sel0", sel_mem_0, 0);
            expect_eq("boot_sel1", sel_mem_1, 0);
        end else begin
            expect_eq("rom_addr", rom_addr, m_pc >> 1);
            expect_eq("pc_1", pc_1, m_pc[0]);
            expect_eq("sel0", sel_mem_0, m_pc[0] ? 2 : 0);
            expect_eq("sel1", sel_mem_1, !m_pc[0]);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic b, input hw_addr_t t);
        rst           = r;
        consume       = c;
        branch_valid  = b;
        branch_target = t;
        @(posedge clk);
        model_edge(r, int'(c), b, t);
        #1;
        check_all();
    endtask

    function automatic logic [1:0] rand_consume();
        int hi;
        hi = (q_pc.size() < 2) ? q_pc.size() : 2;
        return 2'($urandom_range(0, hi));
    endfunction

    initial begin
        rst           = 1'b1;
        consume       = 2'd0;
        branch_valid  = 1'b0;
        branch_target = '0;
        m_boot        = 1'b1;
        m_pc          = '0;
        for (int i = 0; i < NHW; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2000;
        mem[1] = 16'h2105;
        mem[2] = 16'h4288;
        mem[3] = 16'hD003;
        mem[4] = 16'hD100;

        step(1'b1, 2'd0, 1'b0, '0);
        step(1'b1, 2'd0, 1'b0, '0);
        expect_eq("rst_v0", inst0_valid, 0);
        expect_eq("rst_rom_addr", rom_addr, 0);

        // Boot sequence and initial fill with no consumption.
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("boot_v0", inst0_valid, 0);
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("first_fetch_sel1", sel_mem_1, 1);
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("first_inst0", inst0, 16'h2000);
        expect_eq("first_inst1", inst1, 16'h2105);
        expect_eq("first_pc", inst0_pc, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("stall_rom_addr", rom_addr, 2);

        step(1'b0, 2'd2, 1'b0, '0);
        expect_eq("stream_a", inst0, 16'h4288);
        expect_eq("stream_b", inst1, 16'hD003);
        step(1'b0, 2'd2, 1'b0, '0);
        expect_eq("stream_c", inst0, 16'hD100);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd2, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd1, 1'b0, '0);

        // Branch to odd target while full; consume must be ignored.
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 2'd2, 1'b1, hw_addr_t'(7));
        expect_eq("br_v0", inst0_valid, 0);
        expect_eq("br_v1", inst1_valid, 0);
        expect_eq("br_rom_addr", rom_addr, 3);
        expect_eq("br_pc_1", pc_1, 1);
        expect_eq("br_sel0", sel_mem_0, 2);
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("br_inst0", inst0, mem[7]);
        expect_eq("br_inst0_pc", inst0_pc, 7);
        expect_eq("br_inst1", inst1, mem[8]);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd1, 1'b0, '0);

        // Wrap at the top of the halfword space.
        step(1'b0, 2'd0, 1'b1, hw_addr_t'(NHW - 1));
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("wrap_inst0", inst0, mem[NHW-1]);
        expect_eq("wrap_inst1", inst1, mem[0]);
        expect_eq("wrap_pc", inst0_pc, NHW - 1);

        // Reset with three entries queued.
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 2'd1, 1'b0, '0);
        expect_eq("three_v1", inst1_valid, 1);
        step(1'b1, 2'd0, 1'b0, '0);
        expect_eq("midrst_v0", inst0_valid, 0);
        expect_eq("midrst_inst0", inst0, 0);
        expect_eq("midrst_rom_addr", rom_addr, 0);
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 2'd0, 1'b0, '0);
        expect_eq("refetch_inst0", inst0, 16'h2000);

        // Random traffic: consume within occupancy, occasional branch and reset.
        for (int i = 0; i < 600; i++) begin
            logic     r, b;
            hw_addr_t t;
            r = ($urandom_range(0, 79) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = hw_addr_t'($urandom);
            step(r, rand_consume(), b, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
